// File: rtl/common.sv
// common: basic fixed-width scalar types shared across the pipeline.
//   u1  - single bit
//   u32 - 32-bit word
//   u64 - 64-bit doubleword
package common;
  typedef logic        u1;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;
endpackage

// File: rtl/fetch_reg_pkg.sv
// fetch_reg_pkg: skid-buffer occupancy states for the IF/ID register and the
// occupancy transition function shared by the skid FIFO.
//   ST_EMPTY / ST_ONE / ST_FULL - number of buffered instructions (0/1/2).
//   skid_next_state()           - next occupancy given accepted push/pop.
package fetch_reg_pkg;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // push/pop are the already-qualified (accepted) operations.
  function automatic logic [1:0] skid_next_state(input logic [1:0] st,
                                                 input logic       push,
                                                 input logic       pop);
    logic [1:0] nxt;
    nxt = st;
    case (st)
      ST_EMPTY: if (push)         nxt = ST_ONE;
      ST_ONE: begin
        if (push && !pop)         nxt = ST_FULL;
        else if (pop && !push)    nxt = ST_EMPTY;
      end
      ST_FULL:  if (pop && !push) nxt = ST_ONE;
      default:                    nxt = ST_EMPTY;
    endcase
    return nxt;
  endfunction
endpackage

// File: rtl/pipes.sv
// pipes: payload types carried between pipeline stages.
//   fetch_data_t - one fetched instruction: valid flag, its PC and raw encoding.
package pipes;
  import common::*;

  typedef struct packed {
    u1  valid;
    u64 pc;
    u32 raw_instr;
  } fetch_data_t;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: small circular FIFO holding instructions that arrived from fetch
// while decode was held.
//   clk, reset - clock, synchronous active-high reset
//   push, din  - write din at the tail (ignored when full unless also popping)
//   pop        - drop the head entry (ignored when empty)
//   clear      - discard all entries (redirect)
//   head       - oldest entry, valid whenever count != ST_EMPTY
//   count      - occupancy (ST_EMPTY / ST_ONE / ST_FULL)
module fetch_skid
  import pipes::*;
  import fetch_reg_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  fetch_data_t din,
  output fetch_data_t head,
  output logic [1:0]  count
);

  fetch_data_t mem_q [DEPTH];
  logic        rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic        wr_idx;
  logic        push_ok, pop_ok;

  // Popping frees a slot in the same cycle, so full+push+pop is legal.
  assign pop_ok  = pop && (count_q != ST_EMPTY);
  assign push_ok = push && ((count_q != ST_FULL) || pop_ok);

  // Tail sits count entries past the head; when full it lands on the slot
  // being popped, which is read combinationally before being overwritten.
  assign wr_idx  = rd_ptr_q ^ count_q[0];

  assign count_d = skid_next_state(count_q, push_ok, pop_ok);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q  <= ST_EMPTY;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides what is
  // live, and leaving the data array reset-free keeps it plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_idx] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_reg.sv
// fetch_reg: IF/ID pipeline register with a 2-entry skid buffer.
//   clk, reset - clock, synchronous active-high reset
//   dataF      - instruction from fetch (valid is a one-cycle pulse)
//   stallD     - decode hold (OR of downstream stalls)
//   flush      - redirect: drop everything held or arriving
//   dataF_nxt  - registered instruction presented to decode
//   stallF     - fetch must hold its PC and not present a new valid
// Per-cycle priority: reset > flush > stallD > advance.
module fetch_reg
  import pipes::*;
  import fetch_reg_pkg::*;
#(
  parameter int SKID_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  fetch_data_t dataF,
  input  logic        stallD,
  input  logic        flush,
  output fetch_data_t dataF_nxt,
  output logic        stallF
);

  fetch_data_t out_q, out_d;
  fetch_data_t skid_head;
  logic [1:0]  skid_count;
  logic        skid_push, skid_pop;

  fetch_skid #(
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (skid_push),
    .pop   (skid_pop),
    .clear (flush),
    .din   (dataF),
    .head  (skid_head),
    .count (skid_count)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the if/else chain can leave one unassigned and infer a latch.
  always_comb begin
    skid_push = 1'b0;
    skid_pop  = 1'b0;
    out_d     = out_q;
    if (flush) begin
      out_d = '0;
    end else if (stallD) begin
      // Decode holds its instruction; absorb arrivals while space remains.
      skid_push = dataF.valid && (skid_count != ST_FULL);
    end else if (skid_count == ST_EMPTY) begin
      // Nothing buffered: bypass straight through (an invalid input is a bubble).
      out_d = dataF;
    end else begin
      // Drain oldest first; a new arrival queues behind the buffered ones.
      out_d     = skid_head;
      skid_pop  = 1'b1;
      skid_push = dataF.valid;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) out_q <= '0;
    else       out_q <= out_d;
  end

  assign dataF_nxt = out_q;
  // Combinational from stallD: fetch must see the hold in the same cycle.
  assign stallF    = (skid_count == ST_FULL) && stallD && !flush;

  // Fetch must never present an instruction while told to stall.
  assert property (@(posedge clk) disable iff (reset)
                   !(stallD && !flush && dataF.valid && (skid_count == ST_FULL)))
    else $error("fetch_reg: valid instruction presented while skid buffer full");

endmodule

// File: tb/tb_fetch_reg.sv
module tb_fetch_reg;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset;
  fetch_data_t dataF;
  logic        stallD;
  logic        flush;
  fetch_data_t dataF_nxt;
  logic        stallF;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_reg #(
    .SKID_DEPTH (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dataF     (dataF),
    .stallD    (stallD),
    .flush     (flush),
    .dataF_nxt (dataF_nxt),
    .stallF    (stallF)
  );

  // Reference model: the instruction decode currently sees, plus a queue of
  // instructions still waiting behind it, in arrival order.
  fetch_data_t m_cur;
  bit          m_strict;   // pc/raw_instr must match even when not valid
  fetch_data_t m_wait[$];

  typedef struct {
    fetch_data_t d;
    bit          strict;
    bit          stallf;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, record what the DUT must show during this
  // cycle, then advance the model across the coming edge.
  task automatic cycle(input bit rst, input bit sd, input bit fl, input bit v,
                       input logic [63:0] pc, input logic [31:0] ri);
    fetch_data_t d;
    exp_t        e;
    @(posedge clk);
    #1;
    d = '{valid: v, pc: pc, raw_instr: ri};
    reset  = rst;
    stallD = sd;
    flush  = fl;
    dataF  = d;
    e.d      = m_cur;
    e.strict = m_strict;
    e.stallf = (m_wait.size() == 2) && sd && !fl;
    sb.push_back(e);
    if (rst) begin
      m_cur = '0; m_strict = 1'b1; m_wait.delete();
    end else if (fl) begin
      m_cur.valid = 1'b0; m_strict = 1'b0; m_wait.delete();
    end else if (sd) begin
      if (v && m_wait.size() < 2) m_wait.push_back(d);
    end else if (m_wait.size() == 0) begin
      m_cur = d; m_strict = 1'b0;
    end else begin
      m_cur = m_wait.pop_front(); m_strict = 1'b0;
      if (v) m_wait.push_back(d);
    end
  endtask

  // Monitor: compare the DUT against the oldest expectation, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("stallF", 128'(stallF), 128'(e.stallf));
        check("valid", 128'(dataF_nxt.valid), 128'(e.d.valid));
        if (e.strict || e.d.valid) begin
          check("pc", 128'(dataF_nxt.pc), 128'(e.d.pc));
          check("raw_instr", 128'(dataF_nxt.raw_instr), 128'(e.d.raw_instr));
        end
      end
    end
  end

  localparam logic [63:0] PC0 = 64'h8000_0000;

  initial begin
    reset  = 1'b1;
    stallD = 1'b0;
    flush  = 1'b0;
    dataF  = '{valid: 1'b1, pc: PC0, raw_instr: 32'h13};
    @(posedge clk);
    m_cur = '0; m_strict = 1'b1;

    // Reset held two cycles with a valid instruction present.
    cycle(1, 0, 0, 1, PC0, 32'h13);
    cycle(1, 0, 0, 1, PC0, 32'h13);
    // Release: capture, then stream consecutive PCs.
    cycle(0, 0, 0, 1, PC0,        32'h13);
    cycle(0, 0, 0, 1, PC0 + 4,    32'h0010_0093);
    cycle(0, 0, 0, 1, PC0 + 8,    32'h0020_0113);
    cycle(0, 0, 0, 0, 64'h0,      32'h0);

    // Skid: A presented, three stalled cycles while B and C arrive.
    cycle(0, 0, 0, 1, 64'h100, 32'hA);
    cycle(0, 1, 0, 1, 64'h104, 32'hB);
    cycle(0, 1, 0, 1, 64'h108, 32'hC);
    cycle(0, 1, 0, 0, 64'h0,   32'h0);
    cycle(0, 0, 0, 0, 64'h0,   32'h0);
    cycle(0, 0, 0, 0, 64'h0,   32'h0);
    cycle(0, 0, 0, 0, 64'h0,   32'h0);

    // Concurrent push and pop with one entry buffered.
    cycle(0, 0, 0, 1, 64'h200, 32'hA2);
    cycle(0, 1, 0, 1, 64'h204, 32'hB2);
    cycle(0, 0, 0, 1, 64'h208, 32'hC2);
    cycle(0, 0, 0, 0, 64'h0,   32'h0);
    cycle(0, 0, 0, 0, 64'h0,   32'h0);

    // Flush while full with D arriving.
    cycle(0, 0, 0, 1, 64'h300, 32'hA3);
    cycle(0, 1, 0, 1, 64'h304, 32'hB3);
    cycle(0, 1, 0, 1, 64'h308, 32'hC3);
    cycle(0, 1, 1, 1, 64'h30C, 32'hD3);
    cycle(0, 0, 0, 0, 64'h0,   32'h0);
    cycle(0, 0, 0, 0, 64'h0,   32'h0);

    // Reset pulse while full, then a fresh instruction.
    cycle(0, 0, 0, 1, 64'h400, 32'hA4);
    cycle(0, 1, 0, 1, 64'h404, 32'hB4);
    cycle(0, 1, 0, 1, 64'h408, 32'hC4);
    cycle(1, 1, 0, 0, 64'h0,   32'h0);
    cycle(0, 0, 0, 1, 64'h500, 32'hE5);
    cycle(0, 0, 0, 0, 64'h0,   32'h0);
    cycle(0, 0, 0, 0, 64'h0,   32'h0);

    // Randomized traffic obeying the fetch protocol.
    for (int i = 0; i < 3000; i++) begin
      bit rst, sd, fl, v;
      rst = ($urandom % 100) == 0;
      fl  = ($urandom % 32) == 0;
      sd  = ($urandom % 10) < 4;
      v   = !((m_wait.size() == 2) && sd && !fl) && (($urandom % 10) < 7);
      cycle(rst, sd, fl, v, {$urandom, $urandom}, $urandom);
    end
    cycle(0, 0, 0, 0, 64'h0, 32'h0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    check("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
